// File: rtl/sorter_pkg.sv
// Shared definitions for the odd-even merge sorter and its output transmitter.
// Holds the default word width and vector length, the index width they imply,
// and the word type used across the sorter datapath.
package sorter_pkg;

  localparam int DEF_W = 8;
  localparam int DEF_N = 16;
  localparam int IDX_W = $clog2(DEF_N);

  typedef logic [DEF_W-1:0] word_t;

endpackage

// File: rtl/sorted_vec_chk.sv
// Order checker for the sorted-vector transmitter. Remembers the last word
// accepted downstream and raises a sticky flag when a later word of the same
// vector is smaller (unsigned). Only built when SORTED_VEC_TX_CHECK_EN is set.
module sorted_vec_chk #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         beat_fire,
  input  logic         first,
  input  logic [W-1:0] data,
  output logic         sort_err
);

  logic [W-1:0] prev_word;

  // Track the previous accepted word and latch any descending step until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_word <= '0;
      sort_err  <= 1'b0;
    end else if (beat_fire) begin
      prev_word <= data;
      if (!first && (data < prev_word)) begin
        sort_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sorted_vec_tx.sv
// Streaming transmitter for sorted vectors. Captures one N-word vector per
// load handshake and emits it word by word (index 0 first) with a last marker.
// A one-deep pending buffer lets the next vector be handed over while the
// current one drains, so back-to-back vectors stream without a bubble.
// Optional order checking is enabled by defining SORTED_VEC_TX_CHECK_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// load_ready depends only on pending occupancy; out_valid depends only on the
// active buffer; neither ready is derived from the other side's valid.
module sorted_vec_tx
  import sorter_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [W-1:0]         vec_in [0:N-1],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 sort_err
);

  localparam int IB = $clog2(N);
  localparam logic [IB-1:0] LAST_IDX = IB'(N - 1);

  logic [W-1:0]  act_mem  [0:N-1];
  logic [W-1:0]  pend_mem [0:N-1];
  logic          act_v;
  logic          pend_v;
  logic [IB-1:0] idx;

  logic load_fire;
  logic beat_fire;
  logic last_fire;
  logic load_to_act;
  logic load_to_pend;
  logic pend_to_act;

  // Handshake decode and routing of an incoming vector or the pending one.
  always_comb begin
    load_ready   = !pend_v;
    load_fire    = load_valid && load_ready;
    beat_fire    = act_v && out_ready;
    last_fire    = beat_fire && (idx == LAST_IDX);
    // A load only reaches active when it is empty or just finished; pending
    // is necessarily empty in that case because load_ready would be low.
    load_to_act  = load_fire && (!act_v || last_fire);
    load_to_pend = load_fire && act_v && !last_fire;
    pend_to_act  = last_fire && pend_v;
  end

  // Vector storage; contents are don't-care while the matching valid is low.
  always_ff @(posedge clk) begin
    if (pend_to_act) begin
      act_mem <= pend_mem;
    end else if (load_to_act) begin
      act_mem <= vec_in;
    end
    if (load_to_pend) begin
      pend_mem <= vec_in;
    end
  end

  // Buffer occupancy and beat counter; the counter returns to 0 only via the
  // last beat or a fresh capture, so it never runs past N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_v  <= 1'b0;
      pend_v <= 1'b0;
      idx    <= '0;
    end else begin
      act_v  <= load_to_act || pend_to_act || (act_v && !last_fire);
      pend_v <= load_to_pend || (pend_v && !pend_to_act);
      if (load_to_act || last_fire) begin
        idx <= '0;
      end else if (beat_fire) begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Stream outputs come straight from the active buffer and counter.
  always_comb begin
    out_valid = act_v;
    out_data  = act_mem[idx];
    out_idx   = idx;
    out_last  = act_v && (idx == LAST_IDX);
    busy      = act_v || pend_v;
  end

`ifdef SORTED_VEC_TX_CHECK_EN
  sorted_vec_chk #(
    .W(W)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .beat_fire(beat_fire),
    .first    (idx == '0),
    .data     (out_data),
    .sort_err (sort_err)
  );
`else
  assign sort_err = 1'b0;
`endif

endmodule

// File: tb/tb_sorted_vec_tx.sv
// Bench for sorted_vec_tx: directed scenarios plus a randomized phase. Every
// accepted load appends its N words (with index and last marker) to an
// expected stream; a monitor pops and compares on each accepted beat.
module tb_sorted_vec_tx;
  import sorter_pkg::*;

  localparam int W  = DEF_W;
  localparam int N  = DEF_N;
  localparam int IB = $clog2(N);
  localparam int EW = W + IB + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [W-1:0]  vec_in [0:N-1];
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [IB-1:0] out_idx;
  logic          out_last;
  logic          busy;
  logic          sort_err;

  logic [EW-1:0] exp_q[$];
  int            n_vec  = 0;
  int            n_fail = 0;
  bit            rand_en = 1'b0;
  bit            check_en_build;

  sorted_vec_tx #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .vec_in    (vec_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .sort_err  (sort_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream model: a vector accepted downstream is just its words in index order.
  task automatic push_vec();
    for (int l = 0; l < N; l++) begin
      exp_q.push_back({vec_in[l], IB'(l), (l == N - 1)});
    end
  endtask

  task automatic set_ramp();
    for (int l = 0; l < N; l++) vec_in[l] = W'(l);
  endtask

  task automatic set_mod8();
    for (int l = 0; l < N; l++) vec_in[l] = W'(l % 8);
  endtask

  // Random sorted vector, as the sorter would deliver it.
  task automatic set_rand_sorted();
    int vals[$];
    for (int l = 0; l < N; l++) vals.push_back($urandom_range(0, (1 << W) - 1));
    vals.sort();
    for (int l = 0; l < N; l++) vec_in[l] = W'(vals[l]);
  endtask

  // Offer vec_in until accepted (bounded), then record it in the model.
  task automatic load_vec();
    int c = 0;
    load_valid = 1'b1;
    @(negedge clk);
    while (!load_ready && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("load_accept_timeout", int'(load_ready), 1);
    if (load_ready) push_vec();
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Run until the expected stream is consumed; mode 0 always ready,
  // mode 1 the 1,0,0,1 pattern, mode 2 leaves out_ready to the random driver.
  task automatic drain(input int mode);
    int c = 0;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    while (exp_q.size() != 0 && c < 1000) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = pat[c % 4];
      tick();
      c++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  // Random backpressure during the randomized phase.
  always @(posedge clk) begin
    if (rand_en) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic          h_valid = 1'b0;
  logic [W-1:0]  h_data;
  logic [IB-1:0] h_idx;
  logic          h_last;

  always @(negedge clk) begin
    if (rst) begin
      h_valid = 1'b0;
    end else begin
      // A stalled beat must present the same word, index and last marker.
      if (h_valid) begin
        check("hold_data", int'(out_data), int'(h_data));
        check("hold_idx", int'(out_idx), int'(h_idx));
        check("hold_last", int'(out_last), int'(h_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", int'(out_data), int'(e[EW-1 -: W]));
          check("beat_idx", int'(out_idx), int'(e[IB:1]));
          check("beat_last", int'(out_last), int'(e[0]));
        end
      end
      h_valid = out_valid && !out_ready;
      h_data  = out_data;
      h_idx   = out_idx;
      h_last  = out_last;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
`ifdef SORTED_VEC_TX_CHECK_EN
    check_en_build = 1'b1;
`else
    check_en_build = 1'b0;
`endif
    for (int l = 0; l < N; l++) vec_in[l] = '0;

    // Reset state while rst is held high.
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_load_ready", int'(load_ready), 1);
    check("rst_sort_err", int'(sort_err), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic frame with one-cycle latency.
    out_ready = 1'b1;
    set_ramp();
    load_vec();
    check("lat_out_valid", int'(out_valid), 1);
    check("lat_out_idx", int'(out_idx), 0);
    drain(0);
    check("basic_busy", int'(busy), 0);
    check("basic_sort_err", int'(sort_err), 0);

    // Back-to-back: second vector goes to pending, no bubble between frames.
    set_rand_sorted();
    load_vec();
    set_rand_sorted();
    load_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("b2b_valid", int'(out_valid), 1);
      check("b2b_idx", int'(out_idx), i % N);
      if (i == 0) begin
        check("b2b_load_ready0", int'(load_ready), 1);
        push_vec();
      end else if (i < N) begin
        check("b2b_load_ready_full", int'(load_ready), 0);
      end else if (i == N) begin
        check("b2b_load_ready_free", int'(load_ready), 1);
      end
      @(posedge clk);
      #1;
      if (i == 0) load_valid = 1'b0;
    end
    check("b2b_end_valid", int'(out_valid), 0);
    check("b2b_left", exp_q.size(), 0);

    // Backpressure with the 1,0,0,1 pattern.
    out_ready = 1'b0;
    set_rand_sorted();
    load_vec();
    drain(1);
    out_ready = 1'b1;
    tick();
    check("bp_busy", int'(busy), 0);

    // Coincident load on the last beat with pending empty.
    set_ramp();
    load_vec();
    for (int i = 0; i < N - 1; i++) tick();
    check("coin_last", int'(out_last), 1);
    set_rand_sorted();
    load_valid = 1'b1;
    @(negedge clk);
    check("coin_load_ready", int'(load_ready), 1);
    push_vec();
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    check("coin_valid", int'(out_valid), 1);
    check("coin_idx", int'(out_idx), 0);
    check("coin_data", int'(out_data), int'(vec_in[0]));
    drain(0);

    // Mid-frame reset after five beats, with a vector also pending.
    set_rand_sorted();
    load_vec();
    set_rand_sorted();
    load_vec();
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", int'(out_valid), 0);
    check("mrst_load_ready", int'(load_ready), 1);
    check("mrst_busy", int'(busy), 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("mrst_no_beat", int'(out_valid), 0);
    end
    tick();

    // Randomized phase: sorted vectors, random gaps, random backpressure.
    rand_en = 1'b1;
    for (int v = 0; v < 8; v++) begin
      set_rand_sorted();
      load_vec();
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    drain(2);
    rand_en = 1'b0;
    #1;
    out_ready = 1'b1;
    tick();
    tick();
    check("rand_busy", int'(busy), 0);
    check("rand_sort_err", int'(sort_err), 0);

    // Order check: words l % 8 descend at index 8.
    set_mod8();
    load_vec();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("order_err", int'(sort_err), int'(check_en_build && i >= 9));
      @(posedge clk);
      #1;
    end
    tick();
    tick();
    check("order_err_sticky", int'(sort_err), int'(check_en_build));
    check("order_left", exp_q.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    check("order_err_cleared", int'(sort_err), 0);
    tick();
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/sorted_vec_tx.md
# sorted_vec_tx

Streaming transmitter on the output side of the odd-even merge sorter. Captures one N-word sorted vector per load handshake and emits it one word per beat, index 0 first, over a valid/ready stream with a last marker. A one-deep pending buffer lets the sorter hand over the next vector while the current one is still draining.

## Interface
- W, 8, data width per word
- N, 16, words per vector; power of two, ≥ 2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- load_valid  in  1  vec_in holds a vector to capture
- load_ready  out  1  block can accept a vector this cycle
- vec_in  in  W × [0:N-1]  unpacked array of N words, same layout as sorter output `o`
- out_valid  out  1  out_data is valid
- out_ready  in  1  downstream accepts the current beat
- out_data  out  W  current word
- out_idx  out  clog2(N)  index of current word within its vector
- out_last  out  1  current beat is index N-1
- busy  out  1  active or pending buffer occupied
- sort_err  out  1  sticky order-violation flag (see Configuration)

## Operation
- Storage: active buffer (N×W) with valid bit `act_v` and beat counter `idx`; pending buffer (N×W) with valid bit `pend_v`.
- `load_ready = !pend_v`, combinational. No dependence on out_ready.
- Load accept (`load_valid && load_ready`):
  - if `!act_v`, or the last beat is accepted this same cycle: capture into active; `idx ← 0`.
  - else: capture into pending.
- Beat accept (`out_valid && out_ready`): `idx ← idx+1`. On the last beat (`idx == N-1`):
  - if `pend_v`: pending moves to active, `pend_v ← 0`, `idx ← 0`.
  - else if a load is accepted this cycle: the new vector goes to active.
  - else `act_v ← 0`.
- Outputs: `out_valid = act_v`; `out_data = active[idx]`; `out_idx = idx`; `out_last = act_v && idx == N-1`; `busy = act_v || pend_v`.
- Words are sent unmodified. Order is index order. The block does not sort.
- The counter wraps only through the last-beat rule and never exceeds N-1.

## Timing
- Reset, asynchronous: `act_v = pend_v = 0`, `idx = 0`, `sort_err = 0`. Therefore `out_valid = out_last = busy = 0`, `out_data = active[0]` (don't-care), and `load_ready = 1`, including while rst is high.
- Latency: a load accepted at edge k gives `out_valid = 1`, `idx = 0` in the cycle after k.
- Throughput: one beat per cycle while out_ready = 1. N beats per vector. No bubble between vectors when pending is full or a load coincides with the last beat.
- Stalls: while out_ready = 0, out_data, out_idx and out_last hold.
- Reset mid-frame: both buffers are discarded and no further beats are emitted.

## Configuration
- `SORTED_VEC_TX_CHECK_EN` defined:
  - each accepted beat with idx ≠ 0 is compared unsigned against the previous accepted word of the same vector;
  - if `out_data < prev`, sort_err is set one cycle after that beat and holds until rst.
- Not defined:
  - sort_err is tied to 0;
  - no previous-word register is built;
  - the port remains so the interface is identical in both builds.

## Structure
- Shared package `sorter_pkg`:
  - default W and N;
  - `IDX_W = $clog2(N)`;
  - word typedef `word_t`.
- One sub-module, `sorted_vec_chk`: previous-word register plus sticky flag. It is instantiated only under the macro.

## Test plan
- **Basic frame:** reset, then load `vec_in[l] = l` (l = 0..15) with out_ready = 1.
  - Expect out_valid from the next cycle.
  - Expect out_data 0..15 on consecutive cycles, out_last only on the 15 beat.
  - Expect sort_err = 0.
- **Back-to-back:** load a vector, then load a second one while the first drains.
  - Expect load_ready = 0 after the second load.
  - Expect 32 contiguous beats with no bubble.
  - Expect load_ready = 1 one cycle after the 16th beat.
- **Backpressure:** toggle out_ready 1,0,0,1 repeatedly.
  - Expect out_data and out_idx held during each 0 cycle.
  - Expect all 16 words delivered exactly once.
- **Coincident load:** offer a load in the same cycle the last beat is accepted, with pending empty.
  - Expect the next cycle to show out_valid = 1, idx 0, new data.
- **Mid-frame reset:** pulse rst after 5 beats.
  - Expect out_valid = 0 and load_ready = 1 immediately (asynchronously).
  - Expect no further beats.
- **Order check (macro on):** load `vec_in[l] = l % 8`.
  - Expect sort_err to rise one cycle after the idx-8 beat (value 0 < 7) and stay 1 until rst.
  - With the macro off, expect sort_err = 0.
